// File: rtl/irq_controller.sv
// Interrupt controller: arbitrates level requests, pulses trap entry, waits for mret, then acks the served line.
// Define IRQ_RR_EN for round-robin arbitration; the default is fixed lowest-index priority.
module irq_controller #(
  parameter int N_IRQ = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic             int_rst_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_ret_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, TRAP, SERVICE, ACK} state_t;

  state_t           r_state;
  logic [4:0]       r_idx;
  logic [N_IRQ-1:0] w_elig;
  logic             w_anyElig;
  logic [4:0]       w_winIdx;
  logic [N_IRQ-1:0] w_ackVec;

  assign w_elig    = irq_req_i & mie_i;
  assign w_anyElig = |w_elig;

`ifdef IRQ_RR_EN
  logic [4:0] r_ptr;
  int         w_dist;
  int         w_best;

  // Winner is the eligible line closest after the last served index, wrapping at N_IRQ.
  always_comb begin
    w_winIdx = '0;
    w_best   = N_IRQ;
    w_dist   = 0;
    for (int i = 0; i < N_IRQ; i++) begin
      w_dist = i - int'(r_ptr) - 1;
      if (w_dist < 0) w_dist = w_dist + N_IRQ;
      if (w_elig[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_winIdx = 5'(i);
      end
    end
  end
`else
  always_comb begin
    w_winIdx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_winIdx = 5'(i);
    end
  end
`endif

  always_comb begin
    w_ackVec = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (5'(i) == r_idx) w_ackVec[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      int_o     <= 1'b0;
      mcause_o  <= '0;
      irq_ret_o <= '0;
      busy_o    <= 1'b0;
`ifdef IRQ_RR_EN
      r_ptr     <= '0;
`endif
    end else begin
      int_o     <= 1'b0;
      irq_ret_o <= '0;
      case (r_state)
        IDLE: begin
          if (w_anyElig) begin
            r_state  <= TRAP;
            r_idx    <= w_winIdx;
            int_o    <= 1'b1;
            mcause_o <= 32'h8000_0010 + {27'd0, w_winIdx};
            busy_o   <= 1'b1;
          end
        end
        TRAP: r_state <= SERVICE;
        // Requests and mask changes are deliberately ignored until mret retires.
        SERVICE: begin
          if (int_rst_i) begin
            r_state   <= ACK;
            irq_ret_o <= w_ackVec;
          end
        end
        ACK: begin
          r_state  <= IDLE;
          mcause_o <= '0;
          busy_o   <= 1'b0;
`ifdef IRQ_RR_EN
          r_ptr    <= r_idx;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
